// File: rtl/vector_list_seq_if.sv
// Display-list sequencer bus: list-memory read port plus draw_line request side.
interface vector_list_seq_if #(
  parameter int ADDR_W  = 10,
  parameter int COORD_W = 12
);
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_rd;
  logic [31:0]        mem_data;
  logic               line_ready;
  logic               draw;
  logic               jump;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;

  modport master (
    output mem_addr, mem_rd, draw, jump, x, y,
    input  mem_data, line_ready
  );

  modport slave (
    input  mem_addr, mem_rd, draw, jump, x, y,
    output mem_data, line_ready
  );
endinterface

// File: rtl/vector_list_seq.sv
// Vector display-list sequencer feeding draw_line, looping frame after frame.
// VECTOR_FRAME_SYNC_EN: adds frame_tick; each frame restart waits for it.
module vector_list_seq #(
  parameter int ADDR_W  = 10,
  parameter int COORD_W = 12,
  parameter int FC_W    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
`ifdef VECTOR_FRAME_SYNC_EN
  input  logic            frame_tick,
`endif
  vector_list_seq_if.master bus,
  output logic            busy,
  output logic            halted,
  output logic            frame_done,
  output logic [FC_W-1:0] frame_count
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_DATA,
    ISSUE,
    HOLD,
    FRAME_WAIT,
    HALTED
  } state_t;

  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_END  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  state_t             state;
  state_t             state_n;
  logic [ADDR_W-1:0]  ptr;
  logic [1:0]         op;
  logic [COORD_W-1:0] cx;
  logic [COORD_W-1:0] cy;
  logic               tick;
  logic               op_line;
  logic               unused_rsvd;

`ifdef VECTOR_FRAME_SYNC_EN
  assign tick = frame_tick;
`else
  assign tick = 1'b1;
`endif

  assign op_line     = ~op[1];
  assign unused_rsvd = ^bus.mem_data[29:24];

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:       if (run) state_n = FETCH;
      FETCH:      state_n = WAIT_DATA;
      WAIT_DATA:  state_n = ISSUE;
      ISSUE: begin
        unique case (1'b1)
          op_line: begin
            if (!run)
              state_n = IDLE;
            else if (bus.line_ready)
              state_n = HOLD;
          end
          (op == OP_END):  state_n = FRAME_WAIT;
          (op == OP_HALT): state_n = HALTED;
          default:         state_n = ISSUE;
        endcase
      end
      HOLD:       state_n = FETCH;
      FRAME_WAIT: begin
        if (!run)
          state_n = IDLE;
        else if (tick)
          state_n = FETCH;
      end
      HALTED:     if (!run) state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      ptr          <= '0;
      op           <= '0;
      cx           <= '0;
      cy           <= '0;
      bus.mem_addr <= '0;
      bus.mem_rd   <= 1'b0;
      bus.draw     <= 1'b0;
      bus.jump     <= 1'b0;
      bus.x        <= '0;
      bus.y        <= '0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
    end else begin
      state      <= state_n;
      busy       <= !(state_n == IDLE || state_n == HALTED);
      halted     <= (state_n == HALTED);
      bus.mem_rd <= (state_n == FETCH);
      bus.draw   <= 1'b0;
      bus.jump   <= 1'b0;
      frame_done <= 1'b0;
      if (state_n == FETCH)
        bus.mem_addr <= ptr;
      if (state_n == IDLE)
        ptr <= '0;
      unique case (state)
        WAIT_DATA: begin
          op <= bus.mem_data[31:30];
          cx <= bus.mem_data[23:12];
          cy <= bus.mem_data[11:0];
        end
        ISSUE: begin
          if (state_n == HOLD) begin
            bus.draw <= 1'b1;
            bus.jump <= (op == OP_JUMP);
            bus.x    <= cx;
            bus.y    <= cy;
            ptr      <= ptr + 1'b1;
            // Running off the end of the list closes the frame implicitly.
            if (&ptr) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 1'b1;
            end
          end else if (state_n == FRAME_WAIT) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 1'b1;
            ptr         <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_list_seq.sv
// Directed bench for vector_list_seq with a pulse scoreboard and memory model.
module tb_vector_list_seq;
  localparam int AW = 10;
  localparam int CW = 12;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          run = 1'b0;
  logic          busy;
  logic          halted;
  logic          frame_done;
  logic [FW-1:0] frame_count;
`ifdef VECTOR_FRAME_SYNC_EN
  logic          frame_tick = 1'b0;
`endif

  vector_list_seq_if #(.ADDR_W(AW), .COORD_W(CW)) bus ();

  vector_list_seq #(.ADDR_W(AW), .COORD_W(CW), .FC_W(FW)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
`ifdef VECTOR_FRAME_SYNC_EN
    .frame_tick  (frame_tick),
`endif
    .bus         (bus.master),
    .busy        (busy),
    .halted      (halted),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:(1<<AW)-1];

  always @(posedge clk)
    if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_draw = -100;
  int n_draw = 0;
  logic [24:0] exp_q[$];

  function automatic logic [31:0] cmd(input logic [1:0] op,
                                      input logic [11:0] cx,
                                      input logic [11:0] cy);
    return {op, 6'b0, cx, cy};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int k);
    case (k)
      0:       return bus.draw;
      1:       return bus.mem_rd;
      2:       return halted;
      default: return frame_done;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int k, input int budget);
    int n = 0;
    while (!sig(k) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {63'd0, sig(k)}, 64'd1);
  endtask

  task automatic push(input logic j, input int px, input int py);
    exp_q.push_back({j, px[11:0], py[11:0]});
  endtask

  task automatic push_square();
    push(1'b1, 0, 10);
    push(1'b0, 10, 0);
    push(1'b0, 10, 10);
    push(1'b0, 0, 10);
  endtask

  // Pulse monitor: scoreboard pop, spacing and jump qualification.
  always @(negedge clk) begin
    cyc++;
    if (reset && bus.draw) begin
      n_draw++;
      tests++;
      assert (exp_q.size() > 0) else begin
        fails++;
        $error("FAIL pulse_unexpected: observed x=%0d y=%0d expected none",
               bus.x, bus.y);
      end
      if (exp_q.size() > 0)
        chk("pulse", {39'd0, bus.jump, bus.x, bus.y}, {39'd0, exp_q.pop_front()});
      chk("spacing_ok", {63'd0, (cyc - last_draw) >= 4}, 64'd1);
      last_draw = cyc;
    end
    if (reset && bus.jump && !bus.draw)
      chk("jump_alone", 64'd1, 64'd0);
  end

`ifdef VECTOR_FRAME_SYNC_EN
  initial begin
    forever begin
      repeat (99) @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  end
`endif

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int rdc;
    int n0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = cmd(2'b10, 12'd0, 12'd0);
    mem[0] = cmd(2'b01, 12'd0, 12'd10);
    mem[1] = cmd(2'b00, 12'd10, 12'd0);
    mem[2] = cmd(2'b00, 12'd10, 12'd10);
    mem[3] = cmd(2'b00, 12'd0, 12'd10);
    mem[4] = cmd(2'b10, 12'd0, 12'd0);
    bus.line_ready = 1'b1;

    // Reset held with run and line_ready active.
    reset = 1'b0;
    run = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_flags", {58'd0, bus.draw, bus.jump, bus.mem_rd, busy, halted,
                      frame_done}, 64'd0);
    chk("rst_x", {52'd0, bus.x}, 64'd0);
    chk("rst_y", {52'd0, bus.y}, 64'd0);
    chk("rst_addr", {54'd0, bus.mem_addr}, 64'd0);
    chk("rst_fc", {48'd0, frame_count}, 64'd0);

    // Square list, two frames, line_ready held high.
    push_square();
    push_square();
    reset = 1'b1;
    @(negedge clk);
    chk("first_rd", {63'd0, bus.mem_rd}, 64'd1);
    chk("first_addr", {54'd0, bus.mem_addr}, 64'd0);
    repeat (2) @(negedge clk);
    chk("lat_early", {63'd0, bus.draw}, 64'd0);
    @(negedge clk);
    chk("latency", {63'd0, bus.draw}, 64'd1);
    wait_sig("frame1_done", 3, 300);
    chk("fc1", {48'd0, frame_count}, 64'd1);
    wait_sig("refetch_rd", 1, 300);
    chk("refetch_addr", {54'd0, bus.mem_addr}, 64'd0);

    // Backpressure after the first pulse of frame 2.
    wait_sig("bp_first", 0, 20);
    bus.line_ready = 1'b0;
    bad = 0;
    rdc = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.draw) bad++;
      if (bus.mem_rd) rdc++;
    end
    chk("bp_nodraw", bad, 0);
    chk("bp_one_prefetch", rdc, 1);
    chk("bp_xy_hold", {40'd0, bus.x, bus.y}, {40'd0, 12'd0, 12'd10});
    bus.line_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {63'd0, bus.draw}, 64'd1);
    wait_sig("frame2_done", 3, 300);
    chk("fc2", {48'd0, frame_count}, 64'd2);

    // Stop while ISSUE stalls on line_ready.
    bus.line_ready = 1'b0;
    wait_sig("stop_rd", 1, 300);
    chk("stop_addr", {54'd0, bus.mem_addr}, 64'd0);
    repeat (2) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("stop_issue_idle", {62'd0, busy, bus.draw}, 64'd0);

    // HALT at address 2.
    mem[0] = cmd(2'b00, 12'd1, 12'd1);
    mem[1] = cmd(2'b00, 12'd2, 12'd2);
    mem[2] = cmd(2'b11, 12'd0, 12'd0);
    bus.line_ready = 1'b1;
    push(1'b0, 1, 1);
    push(1'b0, 2, 2);
    n0 = n_draw;
    run = 1'b1;
    wait_sig("halt_reach", 2, 60);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!halted || busy) bad++;
    end
    chk("halt_stay", bad, 0);
    chk("halt_pulses", n_draw - n0, 2);
    run = 1'b0;
    @(negedge clk);
    chk("halt_exit", {62'd0, halted, busy}, 64'd0);

    // Restart, then drop run during HOLD.
    push(1'b0, 1, 1);
    run = 1'b1;
    wait_sig("restart_rd", 1, 5);
    chk("restart_addr", {54'd0, bus.mem_addr}, 64'd0);
    wait_sig("restart_draw", 0, 10);
    run = 1'b0;
    wait_sig("hold_inflight_rd", 1, 3);
    chk("hold_inflight_addr", {54'd0, bus.mem_addr}, 64'd1);
    n0 = n_draw;
    repeat (10) @(negedge clk);
    chk("hold_no_pulse", n_draw - n0, 0);
    chk("hold_idle", {63'd0, busy}, 64'd0);

`ifdef VECTOR_FRAME_SYNC_EN
    mem[0] = cmd(2'b01, 12'd0, 12'd10);
    mem[1] = cmd(2'b00, 12'd10, 12'd0);
    mem[2] = cmd(2'b00, 12'd10, 12'd10);
    mem[3] = cmd(2'b00, 12'd0, 12'd10);
    mem[4] = cmd(2'b10, 12'd0, 12'd0);
    for (int f = 0; f < 3; f++) push_square();
    run = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_sig("sync_frame_done", 3, 400);
      chk("sync_fc", {48'd0, frame_count}, 64'(3 + f));
      if (f < 2) begin
        rdc = 0;
        bad = 0;
        while (!frame_tick && bad < 200) begin
          @(negedge clk);
          if (bus.mem_rd && !frame_tick) rdc++;
          bad++;
        end
        chk("sync_no_rd_before_tick", rdc, 0);
      end
    end
    run = 1'b0;
    repeat (5) @(negedge clk);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
